// File: rtl/stream_dot_product.sv
// Streaming dot-product operator for a PRflow leaf user slot.
// Consumes paired elements from streams A and B, accumulates VEC_LEN products
// (wrapping at DATA_W bits), then presents the result on NUM_OUT channels,
// either broadcast to all channels or round-robin, one channel per result.
module stream_dot_product #(
  parameter int DATA_W   = 32,
  parameter int VEC_LEN  = 6,
  parameter int NUM_OUT  = 2,
  parameter int OUT_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_user,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_a_data,
  input  logic                        in_a_vld,
  output logic                        in_a_ack,
  input  logic [DATA_W-1:0]           in_b_data,
  input  logic                        in_b_vld,
  output logic                        in_b_ack,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic [NUM_OUT-1:0]          out_vld,
  input  logic [NUM_OUT-1:0]          out_ack,
  output logic [CNT_W-1:0]            result_cnt,
  output logic                        busy
);

  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   result;
  logic [EW-1:0]       elem_cnt;
  logic [NUM_OUT-1:0]  done;
  logic [PW-1:0]       ptr;

  logic [DATA_W-1:0]   prod;
  logic [DATA_W-1:0]   sum;
  logic [NUM_OUT-1:0]  sel;
  logic [NUM_OUT-1:0]  done_next;
  logic                pair_fire;
  logic                last_pair;
  logic                bc_complete;
  logic                rr_fire;

  // Both streams are consumed together, and only while accumulating.
  assign pair_fire = (state == ACC) && in_a_vld && in_b_vld;
  assign in_a_ack  = pair_fire;
  assign in_b_ack  = pair_fire;
  assign last_pair = (elem_cnt == EW'(VEC_LEN - 1));

  // Product and running sum, truncated to DATA_W bits (sign-agnostic wrap).
  always_comb begin
    prod = in_a_data * in_b_data;
    sum  = acc + prod;
  end

  // One-hot decode of the round-robin pointer.
  always_comb begin
    sel      = '0;
    sel[ptr] = 1'b1;
  end

  // Channel valids: every not-yet-acked channel (broadcast) or the selected one.
  always_comb begin
    if (state == OUT) begin
      if (OUT_MODE == 0) begin
        out_vld = ~done;
      end else begin
        out_vld = sel;
      end
    end else begin
      out_vld = '0;
    end
  end

  // Completion terms; acks on channels that are not valid are ignored.
  always_comb begin
    done_next   = done | (out_ack & out_vld);
    bc_complete = &done_next;
    rr_fire     = |(out_ack & sel);
  end

  // The result register drives every channel; invalid channels are don't-care.
  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_out
      assign out_data[k*DATA_W +: DATA_W] = result;
    end
  endgenerate

  assign busy = (elem_cnt != '0) || (state == OUT);

  // Accumulate / output state machine.
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      state      <= ACC;
      acc        <= '0;
      elem_cnt   <= '0;
      result     <= '0;
      done       <= '0;
      ptr        <= '0;
      result_cnt <= '0;
    end else begin
      case (state)
        ACC: begin
          if (pair_fire) begin
            if (last_pair) begin
              result   <= sum;
              acc      <= '0;
              elem_cnt <= '0;
              state    <= OUT;
            end else begin
              acc      <= sum;
              elem_cnt <= elem_cnt + EW'(1);
            end
          end
        end
        OUT: begin
          if (OUT_MODE == 0) begin
            if (bc_complete) begin
              done       <= '0;
              result_cnt <= result_cnt + CNT_W'(1);
              state      <= ACC;
            end else begin
              done <= done_next;
            end
          end else if (rr_fire) begin
            ptr        <= (ptr == PW'(NUM_OUT - 1)) ? '0 : ptr + PW'(1);
            result_cnt <= result_cnt + CNT_W'(1);
            state      <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
